traffic_display_scan: RTL and testbench
=======================================

Name: traffic_display_scan

Overview:
- Consumer side of the traffic controller's countdown outputs.
- Takes the four BCD countdown digits (A2/A1 for road A, B2/B1 for road B) and the A_light/B_light lamp signals.
- Drives one time-multiplexed 4-digit common-anode 7-segment display: frame-synchronous snapshot, anti-ghosting dead time, leading-zero blanking, invalid-BCD flagging.
- Sits between the controller and the board pins.

Parameters:
- SCAN_DIV, 1000: Clk cycles per digit slot; legal range is 2 or more.
- DEAD, 8: cycles at the start of each slot with all digits off; must satisfy 0 ≤ DEAD < SCAN_DIV.
- BLANK_LZ, 1: when 1, a tens digit equal to 0 is blanked.

Ports:
- Clk  in  1  system clock; everything is on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- A1  in  [0:3]  road A units, BCD; bit 0 is the MSB.
- A2  in  [0:3]  road A tens, BCD.
- B1  in  [0:3]  road B units, BCD.
- B2  in  [0:3]  road B tens, BCD.
- A_light  in  1  road A digits are shown only while this is 1.
- B_light  in  1  road B digits are shown only while this is 1.
- Seg  out  [0:6]  segments a..g, active low.
- Dig  out  [0:3]  digit enables, active low; Dig[0]=A2, Dig[1]=A1, Dig[2]=B2, Dig[3]=B1.
- Err  out  1  sticky flag: a displayed digit was greater than 9.

Behaviour:
- Reset (Reset_n=0, takes effect asynchronously):
  - prescaler p=0, slot index idx=0
  - snapshot digits=0, snapshot lights=0
  - Dig=1111, Seg=1111111, Err=0
- Prescaler: p counts 0..SCAN_DIV-1 and wraps.
  - When p=SCAN_DIV-1, idx advances 0→1→2→3→0.
  - Frame period is 4*SCAN_DIV cycles.
- Snapshot: on the edge where idx=3 and p=SCAN_DIV-1, register A2, A1, B2, B1, A_light and B_light.
  - The snapshot is used for the whole next frame.
  - Input changes inside a frame never appear mid-frame (no tearing).
- Visible digit for slot idx requires all of:
  - that road's snapshot light is 1;
  - not (BLANK_LZ=1 and idx is 0 or 2 and the snapshot digit is 0000).
- Output registers have 1-cycle latency: Dig/Seg at cycle t+1 are a function of (idx, p, snapshot) at cycle t.
  - p < DEAD, or digit not visible: Dig=1111, Seg=1111111.
  - Otherwise: Dig has only bit idx low; Seg=decode(digit).
- Decode, active-low, bit order a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 1010..1111 → dash 1111110
- Err is set on the same edge as a visible dash is registered.
  - It stays 1 until Reset_n; later valid data does not clear it.
- Units digits (idx 1, 3) are never leading-zero blanked.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for Clk.
  - After Reset_n rises, scanning restarts at idx=0, p=0.
  - The display stays dark until the first snapshot, because the snapshot lights are 0.
- DEAD=0: the digit is driven for the full slot.
- Simultaneous snapshot edge and input change: the value present at that edge is captured.

Decomposition:
- Shared package traffic_disp_pkg holds:
  - the segment encoding constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the slot index constants IDX_A2, IDX_A1, IDX_B2, IDX_B1;
  - the digit-enable all-off constant.
- One combinational sub-module, bcd_to_seg7:
  - input: 4-bit BCD; outputs: 7-bit active-low segments and an invalid flag.
  - Instantiated once on the muxed snapshot digit.
- Prescaler, slot index, snapshot, output registers and Err live in the top.

Test Plan:
- Async reset: assert Reset_n=0 mid-slot with Dig=1011 → Dig=1111, Seg=1111111 and Err=0 before the next Clk edge. After release, idx=0 and the display stays dark for the first frame.
- SCAN_DIV=4, DEAD=1, A_light=1, A2=0010, A1=0101, B_light=0, after one snapshot:
  - slot 0: 1 cycle Dig=1111, then 3 cycles Dig=0111 with Seg=0010010;
  - slot 1: Dig=1011 with Seg=0100100;
  - slots 2 and 3: Dig=1111;
  - frame repeats every 16 cycles.
- Leading zero, A2=0000, A1=0111:
  - BLANK_LZ=1: slot 0 shows Dig=1111; slot 1 shows Seg=0001111.
  - BLANK_LZ=0: slot 0 shows Dig=0111, Seg=0000001.
- Anti-tearing: change A1 from 0101 to 1001 during slot 2 → Seg in slot 1 stays 0100100 for the rest of that frame and becomes 0000100 only in the next frame.
- Invalid BCD: B_light=1, B1=1100 → slot 3 shows Seg=1111110 and Err rises with it. Set B1=0011 → slot 3 shows 0000110 and Err stays 1 until Reset_n.
- Road blanking: A_light changes 1→0 mid-frame → A digits remain visible to frame end and go dark (Dig[0:1]=11) from the next frame.

Source files
------------

// File: rtl/traffic_disp_pkg.sv
// -----------------------------------------------------------------------------
// traffic_disp_pkg
// Shared constants for the traffic countdown display scanner.
//   - SEG_*   : active-low segment patterns, bit order a..g (index 0 = a)
//   - IDX_*   : scan slot index of each display digit
//   - DIG_OFF : digit-enable pattern with every digit switched off
//   - dig_select() : active-low one-cold digit enable for a slot index
// -----------------------------------------------------------------------------
package traffic_disp_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] IDX_A2 = 2'd0;
  localparam logic [1:0] IDX_A1 = 2'd1;
  localparam logic [1:0] IDX_B2 = 2'd2;
  localparam logic [1:0] IDX_B1 = 2'd3;

  localparam logic [0:3] DIG_OFF = 4'b1111;

  // Digit enable with only the bit for slot idx pulled low (Dig[0] = slot 0).
  function automatic logic [0:3] dig_select(input logic [1:0] idx);
    logic [0:3] d;
    d      = DIG_OFF;
    d[idx] = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to 7-segment decoder, active-low segments.
// Ports:
//   bcd_i     [0:3] BCD digit, bit 0 is the MSB
//   seg_o     [0:6] segments a..g, active low; codes above 9 give a dash
//   invalid_o       1 when the input is not a legal BCD digit (> 9)
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import traffic_disp_pkg::*;
(
  input  logic [0:3] bcd_i,
  output logic [0:6] seg_o,
  output logic       invalid_o
);

  // Segment lookup; every non-BCD code collapses onto the dash pattern.
  always_comb begin
    seg_o     = SEG_DASH;
    invalid_o = 1'b0;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: begin
        seg_o     = SEG_DASH;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/traffic_display_scan.sv
// -----------------------------------------------------------------------------
// traffic_display_scan
// Time-multiplexed 4-digit common-anode display driver for the traffic
// controller countdown. Inputs are snapshotted once per frame so a frame is
// never torn, each slot opens with DEAD dark cycles against ghosting, tens
// digits of 0 may be blanked, and any shown non-BCD digit latches Err.
// Ports:
//   Clk       system clock, rising edge
//   Reset_n   asynchronous active-low reset
//   A2/A1     road A tens/units BCD, bit 0 = MSB
//   B2/B1     road B tens/units BCD, bit 0 = MSB
//   A_light   road A digits shown only while 1
//   B_light   road B digits shown only while 1
//   Seg [0:6] segments a..g, active low, registered
//   Dig [0:3] digit enables, active low (A2, A1, B2, B1), registered
//   Err       sticky: a displayed digit was above 9
// -----------------------------------------------------------------------------
module traffic_display_scan
  import traffic_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEAD     = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [0:3] A1,
  input  logic [0:3] A2,
  input  logic [0:3] B1,
  input  logic [0:3] B2,
  input  logic       A_light,
  input  logic       B_light,
  output logic [0:6] Seg,
  output logic [0:3] Dig,
  output logic       Err
);

  localparam int             PW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  DEAD_P = PW'(DEAD);

  logic [PW-1:0] p_q, p_d;
  logic [1:0]    idx_q, idx_d;

  logic [0:3]    snap_a2_q, snap_a1_q, snap_b2_q, snap_b1_q;
  logic [0:3]    snap_a2_d, snap_a1_d, snap_b2_d, snap_b1_d;
  logic          snap_al_q, snap_bl_q, snap_al_d, snap_bl_d;

  logic [0:6]    seg_q, seg_d;
  logic [0:3]    dig_q, dig_d;
  logic          err_q, err_d;

  logic          slot_end_s;
  logic          frame_end_s;
  logic [0:3]    cur_digit_s;
  logic          cur_light_s;
  logic          cur_tens_s;
  logic          visible_s;
  logic          drive_s;
  logic [0:6]    dec_seg_s;
  logic          dec_invalid_s;

  // Prescaler, slot index and frame-boundary snapshot next-state.
  always_comb begin
    slot_end_s  = (p_q == P_LAST);
    frame_end_s = slot_end_s && (idx_q == IDX_B1);
    snap_a2_d   = snap_a2_q;
    snap_a1_d   = snap_a1_q;
    snap_b2_d   = snap_b2_q;
    snap_b1_d   = snap_b1_q;
    snap_al_d   = snap_al_q;
    snap_bl_d   = snap_bl_q;
    if (slot_end_s) begin
      p_d   = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      p_d   = p_q + PW'(1);
      idx_d = idx_q;
    end
    // Capture on the last cycle of slot 3 so the whole next frame sees one
    // consistent set of digits and lamps.
    if (frame_end_s) begin
      snap_a2_d = A2;
      snap_a1_d = A1;
      snap_b2_d = B2;
      snap_b1_d = B1;
      snap_al_d = A_light;
      snap_bl_d = B_light;
    end else begin
      snap_al_d = snap_al_q;
      snap_bl_d = snap_bl_q;
    end
  end

  // Select the snapshot digit and lamp belonging to the current slot.
  always_comb begin
    cur_digit_s = snap_a2_q;
    cur_light_s = snap_al_q;
    cur_tens_s  = 1'b1;
    case (idx_q)
      IDX_A2: begin
        cur_digit_s = snap_a2_q;
        cur_light_s = snap_al_q;
        cur_tens_s  = 1'b1;
      end
      IDX_A1: begin
        cur_digit_s = snap_a1_q;
        cur_light_s = snap_al_q;
        cur_tens_s  = 1'b0;
      end
      IDX_B2: begin
        cur_digit_s = snap_b2_q;
        cur_light_s = snap_bl_q;
        cur_tens_s  = 1'b1;
      end
      IDX_B1: begin
        cur_digit_s = snap_b1_q;
        cur_light_s = snap_bl_q;
        cur_tens_s  = 1'b0;
      end
      default: begin
        cur_digit_s = snap_a2_q;
        cur_light_s = 1'b0;
        cur_tens_s  = 1'b0;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i     (cur_digit_s),
    .seg_o     (dec_seg_s),
    .invalid_o (dec_invalid_s)
  );

  // Output next-state: dark during dead time or when the digit is hidden.
  always_comb begin
    visible_s = cur_light_s &&
                !((BLANK_LZ != 0) && cur_tens_s && (cur_digit_s == 4'b0000));
    drive_s   = visible_s && !(p_q < DEAD_P);
    if (drive_s) begin
      dig_d = dig_select(idx_q);
      seg_d = dec_seg_s;
    end else begin
      dig_d = DIG_OFF;
      seg_d = SEG_BLANK;
    end
    // Err latches on the same edge the dash is registered onto the pins.
    if (drive_s && dec_invalid_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Scan counters and snapshot registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_q       <= '0;
      idx_q     <= IDX_A2;
      snap_a2_q <= 4'b0000;
      snap_a1_q <= 4'b0000;
      snap_b2_q <= 4'b0000;
      snap_b1_q <= 4'b0000;
      snap_al_q <= 1'b0;
      snap_bl_q <= 1'b0;
    end else begin
      p_q       <= p_d;
      idx_q     <= idx_d;
      snap_a2_q <= snap_a2_d;
      snap_a1_q <= snap_a1_d;
      snap_b2_q <= snap_b2_d;
      snap_b1_q <= snap_b1_d;
      snap_al_q <= snap_al_d;
      snap_bl_q <= snap_bl_d;
    end
  end

  // Registered display outputs and sticky error flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_q <= SEG_BLANK;
      dig_q <= DIG_OFF;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      err_q <= err_d;
    end
  end

  assign Seg = seg_q;
  assign Dig = dig_q;
  assign Err = err_q;

endmodule

// File: tb/tb_traffic_display_scan.sv
// -----------------------------------------------------------------------------
// tb_traffic_display_scan
// Directed bench: SCAN_DIV=4, DEAD=1. Two instances share all inputs, one with
// leading-zero blanking and one without. Edge n after reset release registers
// the output for slot ((n-1)/4)%4, prescaler (n-1)%4; a snapshot lands on
// every edge n that is a multiple of 16.
// -----------------------------------------------------------------------------
module tb_traffic_display_scan;

  logic       Clk;
  logic       Reset_n;
  logic [0:3] A1, A2, B1, B2;
  logic       A_light, B_light;
  logic [0:6] seg1, seg0;
  logic [0:3] dig1, dig0;
  logic       err1, err0;

  int checks;
  int errors;
  int ecount;

  traffic_display_scan #(.SCAN_DIV(4), .DEAD(1), .BLANK_LZ(1)) dut_lz (
    .Clk(Clk), .Reset_n(Reset_n), .A1(A1), .A2(A2), .B1(B1), .B2(B2),
    .A_light(A_light), .B_light(B_light), .Seg(seg1), .Dig(dig1), .Err(err1)
  );

  traffic_display_scan #(.SCAN_DIV(4), .DEAD(1), .BLANK_LZ(0)) dut_nz (
    .Clk(Clk), .Reset_n(Reset_n), .A1(A1), .A2(A2), .B1(B1), .B2(B2),
    .A_light(A_light), .B_light(B_light), .Seg(seg0), .Dig(dig0), .Err(err0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk_out(input string tag, input logic [0:3] dig_act,
                         input logic [0:6] seg_act, input logic [0:3] dig_exp,
                         input logic [0:6] seg_exp);
    checks++;
    assert (dig_act === dig_exp && seg_act === seg_exp) else begin
      errors++;
      $error("FAIL %s: got Dig=%b Seg=%b, want Dig=%b Seg=%b",
             tag, dig_act, seg_act, dig_exp, seg_exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic act, input logic exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got Err=%b, want Err=%b", tag, act, exp);
    end
  endtask

  // Advance to the negedge following posedge n (counted from reset release).
  task automatic to_edge(input int n);
    while (ecount < n) begin
      @(negedge Clk);
      ecount++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ecount  = 0;
    Reset_n = 1'b0;
    A2 = 4'b0010; A1 = 4'b0101; B2 = 4'b0000; B1 = 4'b0000;
    A_light = 1'b1; B_light = 1'b0;

    repeat (3) @(negedge Clk);
    chk_out("reset_state", dig1, seg1, 4'b1111, 7'b1111111);
    chk_err("reset_err", err1, 1'b0);
    Reset_n = 1'b1;
    ecount  = 0;

    // First frame: snapshot lamps still 0, so nothing lights.
    to_edge(2);  chk_out("dark_f1_s0", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(6);  chk_out("dark_f1_s1", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(16); chk_out("dark_f1_end", dig1, seg1, 4'b1111, 7'b1111111);

    // Frame 2: A=25 shown, B dark.
    to_edge(17); chk_out("f2_s0_dead", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(18); chk_out("f2_s0_a2", dig1, seg1, 4'b0111, 7'b0010010);
    to_edge(20); chk_out("f2_s0_a2_last", dig1, seg1, 4'b0111, 7'b0010010);
    to_edge(21); chk_out("f2_s1_dead", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(22); chk_out("f2_s1_a1", dig1, seg1, 4'b1011, 7'b0100100);
    to_edge(26); chk_out("f2_s2_dark", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(30); chk_out("f2_s3_dark", dig1, seg1, 4'b1111, 7'b1111111);
    chk_err("f2_err", err1, 1'b0);

    // Frame 3: same picture repeats; A1 changes mid-frame and must not tear.
    to_edge(34); chk_out("f3_s0_repeat", dig1, seg1, 4'b0111, 7'b0010010);
    A1 = 4'b1001;
    to_edge(38); chk_out("f3_s1_no_tear", dig1, seg1, 4'b1011, 7'b0100100);
    to_edge(54); chk_out("f4_s1_new_a1", dig1, seg1, 4'b1011, 7'b0000100);

    // Leading zero: A2=0, A1=7 from frame 5.
    to_edge(56);
    A2 = 4'b0000; A1 = 4'b0111;
    to_edge(66);
    chk_out("f5_lz_blank", dig1, seg1, 4'b1111, 7'b1111111);
    chk_out("f5_lz_shown", dig0, seg0, 4'b0111, 7'b0000001);

    // Road A lamp drops mid-frame; B lamp up with an invalid units digit.
    to_edge(67);
    A_light = 1'b0; B_light = 1'b1; B2 = 4'b0000; B1 = 4'b1100;
    to_edge(70); chk_out("f5_a1_still_lit", dig1, seg1, 4'b1011, 7'b0001111);
    to_edge(78); chk_out("f5_b_not_yet", dig1, seg1, 4'b1111, 7'b1111111);
    chk_err("f5_err_clear", err1, 1'b0);
    to_edge(82); chk_out("f6_a2_dark", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(86); chk_out("f6_a1_dark", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(90);
    chk_out("f6_b2_lz_blank", dig1, seg1, 4'b1111, 7'b1111111);
    chk_out("f6_b2_lz_shown", dig0, seg0, 4'b1101, 7'b0000001);
    to_edge(93); chk_err("f6_err_before_dash", err1, 1'b0);
    to_edge(94);
    chk_out("f6_b1_dash", dig1, seg1, 4'b1110, 7'b1111110);
    chk_err("f6_err_with_dash", err1, 1'b1);

    // Valid data afterwards does not clear Err.
    B1 = 4'b0011;
    to_edge(110);
    chk_out("f7_b1_valid", dig1, seg1, 4'b1110, 7'b0000110);
    chk_err("f7_err_sticky", err1, 1'b1);

    // Relight road A for the async reset test.
    A_light = 1'b1;
    to_edge(118);
    chk_out("f8_a1_before_rst", dig1, seg1, 4'b1011, 7'b0001111);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_out("async_rst_out", dig1, seg1, 4'b1111, 7'b1111111);
    chk_err("async_rst_err", err1, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ecount  = 0;

    // Dark for the first frame, then scanning restarts at slot 0.
    to_edge(2);  chk_out("post_rst_dark_s0", dig0, seg0, 4'b1111, 7'b1111111);
    to_edge(6);  chk_out("post_rst_dark_s1", dig1, seg1, 4'b1111, 7'b1111111);
    to_edge(18); chk_out("post_rst_s0", dig0, seg0, 4'b0111, 7'b0000001);
    to_edge(22); chk_out("post_rst_s1", dig1, seg1, 4'b1011, 7'b0001111);
    chk_err("post_rst_err", err1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
